alu_regfile: RTL
================

// Module: alu_regfile
// PURPOSE
//  Register file feeding the 4-bit ALU operand inputs (a, b) one stage upstream.
//  Two combinational read ports supply the ALU operands.
//  One clocked write port accepts the ALU result for write-back.
//  Also holds a registered copy of the ALU zero output (branch flag) for the control FSM.
// PARAMETERS
//  WIDTH  4  data width in bits; matches the ALU operand/result width
//  AW     3  address width; register count = 2**AW (8)
// PORTS
//  clk        in   1      system clock; all state updates on rising edge
//  rst_n      in   1      synchronous reset, active-low
//  ra1        in   AW     read address, port 1 (drives ALU a)
//  ra2        in   AW     read address, port 2 (drives ALU b)
//  rd1        out  WIDTH  read data, port 1
//  rd2        out  WIDTH  read data, port 2
//  we         in   1      write enable
//  wa         in   AW     write address
//  wd         in   WIDTH  write data (ALU result)
//  flag_we    in   1      capture enable for zero flag
//  zero_in    in   1      ALU zero output
//  zero_flag  out  1      registered zero flag
// BEHAVIOUR
//  Storage
//   - 2**AW registers of WIDTH bits.
//   - Register 0 reads as 0 at all times; writes to address 0 are discarded.
//  Reset
//   - Sampled only at rising clk while rst_n=0.
//   - Clears all registers and zero_flag to 0 on that edge.
//   - Reset has priority over we and flag_we in the same cycle.
//   - Reset asserted mid-sequence discards any pending write.
//   - No asynchronous effect: between edges, contents are unchanged by rst_n.
//  Write
//   - On rising clk with rst_n=1 and we=1 and wa!=0: reg[wa] <= wd.
//   - Write latency 1 cycle.
//   - we=0: no register changes.
//  Read
//   - Combinational, 0-cycle latency.
//   - rdN = (raN==0) ? 0 : reg[raN].
//   - Write-through bypass: if rst_n=1, we=1, wa!=0 and raN==wa, then rdN = wd in
//     the same cycle (new value, not the stale one).
//   - Both ports may address the same register; both then return identical data,
//     including under bypass.
//   - Bypass is inactive while rst_n=0; reads return stored contents.
//  Zero flag
//   - On rising clk with rst_n=1 and flag_we=1: zero_flag <= zero_in.
//   - Otherwise holds its value.
//   - Independent of we; both may update in the same cycle.
//  Arithmetic/width
//   - No arithmetic is performed; wd is stored verbatim in WIDTH bits.
//   - Addresses are fully decoded; there is no out-of-range case.
//  Outputs
//   - rd1/rd2 are X-free after the first reset edge.
//   - zero_flag = 0 after reset.
// TESTING
//  1. rst_n=0 one edge, then read all 8 addrs on both ports -> all 0; zero_flag=0
//  2. we=1 wa=3 wd=4'b0111, next cycle ra1=3 ra2=3 -> rd1=rd2=0111
//  3. we=1 wa=5 wd=4'b1110 with ra1=5 same cycle -> rd1=1110 before edge (bypass);
//     after edge, we=0 -> rd1 still 1110
//  4. we=1 wa=0 wd=4'b1111 -> ra1=0 gives 0 both during and after the cycle;
//     no bypass on address 0
//  5. regs 3=0111 and 5=1110 loaded; rst_n=0 with we=1 wa=3 wd=0001 same edge
//     -> reg3=0, reg5=0 (reset wins)
//  6. flag_we=1 zero_in=1 -> zero_flag=1 next cycle;
//     flag_we=0 zero_in=0 -> zero_flag stays 1;
//     flag_we=1 zero_in=0 -> zero_flag=0

Source files
------------

// File: rtl/alu_regfile.sv
// ============================================================================
// Module   : alu_regfile
// Purpose  : 2**AW x WIDTH register file with two combinational read ports,
//            one write port with write-through bypass, and a registered ALU
//            zero flag. Register 0 is hardwired to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_regfile #(
  parameter int WIDTH = 4,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             flag_we,
  input  logic             zero_in,
  output logic             zero_flag
);

  localparam int c_nregs = 2 ** AW;

  logic [WIDTH-1:0] regs_q [c_nregs];
  logic [WIDTH-1:0] regs_d [c_nregs];
  logic             zero_flag_q;
  logic             zero_flag_d;
  logic             w_wr_en;

  // A write that will actually land at the next edge; also gates the bypass.
  assign w_wr_en = rst_n && we && (wa != '0);

  always_comb begin
    regs_d      = regs_q;
    zero_flag_d = zero_flag_q;
    if (!rst_n) begin
      for (int i = 0; i < c_nregs; i++) begin
        regs_d[i] = '0;
      end
      zero_flag_d = 1'b0;
    end else begin
      if (w_wr_en) begin
        regs_d[wa] = wd;
      end
      if (flag_we) begin
        zero_flag_d = zero_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    regs_q      <= regs_d;
    zero_flag_q <= zero_flag_d;
  end

  always_comb begin
    rd1 = regs_q[ra1];
    if (ra1 == '0) begin
      rd1 = '0;
    end else if (w_wr_en && (ra1 == wa)) begin
      rd1 = wd;
    end
  end

  always_comb begin
    rd2 = regs_q[ra2];
    if (ra2 == '0) begin
      rd2 = '0;
    end else if (w_wr_en && (ra2 == wa)) begin
      rd2 = wd;
    end
  end

  assign zero_flag = zero_flag_q;

endmodule

`default_nettype wire
